// File: rtl/l2_coherence_request_sequencer.sv
// l2_coherence_request_sequencer
// Front end of the MESI arbiter. Picks one pending coherence request from the
// four L2 instances (round-robin), snoops the other three L2s for their copy of
// the block, then presents a single stable request to the arbiter and runs the
// verify/acknowledge handshake before returning the MESI state to the requester.
//
// Optional build macro: ARB_SEQ_TIMEOUT_EN
//   When defined, an ISSUE watchdog forces an INVALID response after
//   ISSUE_TIMEOUT cycles without arbiter_verify and sets the sticky timeout_err.
module l2_coherence_request_sequencer #(
   parameter int ADDRESS_WIDTH          = 32,
   parameter int MAIN_MEMORY_DATA_WIDTH = 32,
   parameter int MESI_STATE_WIDTH       = 2
`ifdef ARB_SEQ_TIMEOUT_EN
   ,
   parameter int ISSUE_TIMEOUT          = 32
`endif
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [3:0]                          req_valid,
   input  logic [3:0]                          req_is_write,
   input  logic [4*ADDRESS_WIDTH-1:0]          req_addr,
   input  logic [4*MAIN_MEMORY_DATA_WIDTH-1:0] req_data,
   output logic [ADDRESS_WIDTH-1:0]            snoop_addr,
   output logic [3:0]                          snoop_req,
   input  logic [4*MAIN_MEMORY_DATA_WIDTH-1:0] snoop_data,
   output logic [ADDRESS_WIDTH-1:0]            block_to_determine_mesi_state_from_arbiter,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]   L2a_local_data,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]   L2b_local_data,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]   L2c_local_data,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]   L2d_local_data,
   output logic                                arbiter_read_update_from_L2_cache_modules,
   output logic                                arbiter_write_update_from_L2_cache_modules,
   output logic                                acknowledge_arbiter_verify,
   input  logic [MESI_STATE_WIDTH-1:0]         mesi_state_to_cache,
   input  logic                                arbiter_verify,
   output logic [3:0]                          resp_valid,
   output logic [MESI_STATE_WIDTH-1:0]         resp_mesi_state,
   output logic                                busy
`ifdef ARB_SEQ_TIMEOUT_EN
   ,
   output logic                                timeout_err
`endif
);

   localparam int NUM_L2 = 4;
   localparam int AW     = ADDRESS_WIDTH;
   localparam int DW     = MAIN_MEMORY_DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      CAPTURE,
      ISSUE,
      ACK,
      DRAIN
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [1:0]            rr_ptr;
   logic [1:0]            grant_idx;
   logic [1:0]            next_grant;
   logic                  grant_found;
   logic [3:0]            grant_onehot;
   logic [AW-1:0]         lat_addr;
   logic                  lat_is_write;
   logic [DW-1:0]         lat_req_data;
   logic [DW-1:0]         slot_data [NUM_L2];
   logic [MESI_STATE_WIDTH-1:0] lat_mesi;
   logic                  verify_armed;
   logic                  verify_accept;
   logic                  timeout_hit;

   assign grant_onehot = 4'b0001 << grant_idx;

   // A verify only counts once the arbiter has been seen low since leaving the
   // previous transaction, so a level left over from before ISSUE is ignored.
   assign verify_accept = (state == ISSUE) && arbiter_verify && verify_armed;

`ifdef ARB_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(ISSUE_TIMEOUT + 1);
   logic [CW-1:0] issue_count;

   assign timeout_hit = (state == ISSUE) && !verify_accept &&
                        (issue_count == CW'(ISSUE_TIMEOUT - 1));

   // Watchdog: counts ISSUE cycles and remembers forever that it ever fired.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ISSUE)
            issue_count <= issue_count + 1'b1;
         else
            issue_count <= '0;
         if (timeout_hit)
            timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Round-robin search: first pending requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      next_grant  = rr_ptr;
      for (int i = 0; i < NUM_L2; i++) begin
         if (!grant_found && req_valid[rr_ptr + 2'(i)]) begin
            grant_found = 1'b1;
            next_grant  = rr_ptr + 2'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state and output decode; outputs are only driven in the state that
   // owns them so the arbiter never sees a partial or stale request.
   always_comb begin
      next_state = state;
      snoop_addr = '0;
      snoop_req  = '0;
      block_to_determine_mesi_state_from_arbiter = '0;
      L2a_local_data = '0;
      L2b_local_data = '0;
      L2c_local_data = '0;
      L2d_local_data = '0;
      arbiter_read_update_from_L2_cache_modules  = 1'b0;
      arbiter_write_update_from_L2_cache_modules = 1'b0;
      acknowledge_arbiter_verify = 1'b0;
      resp_valid      = '0;
      resp_mesi_state = '0;
      busy            = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant_found)
               next_state = SNOOP;
         end
         SNOOP: begin
            snoop_addr = lat_addr;
            snoop_req  = ~grant_onehot;
            next_state = CAPTURE;
         end
         CAPTURE: begin
            next_state = ISSUE;
         end
         ISSUE: begin
            block_to_determine_mesi_state_from_arbiter = lat_addr;
            L2a_local_data = slot_data[0];
            L2b_local_data = slot_data[1];
            L2c_local_data = slot_data[2];
            L2d_local_data = slot_data[3];
            arbiter_read_update_from_L2_cache_modules  = !lat_is_write;
            arbiter_write_update_from_L2_cache_modules = lat_is_write;
            if (verify_accept || timeout_hit)
               next_state = ACK;
         end
         ACK: begin
            acknowledge_arbiter_verify = 1'b1;
            resp_valid      = grant_onehot;
            resp_mesi_state = lat_mesi;
            next_state      = DRAIN;
         end
         DRAIN: begin
            acknowledge_arbiter_verify = 1'b1;
            if (!arbiter_verify)
               next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Transaction datapath: latch the winner in IDLE, merge snoop results in
   // CAPTURE, take the arbiter's verdict in ISSUE and advance fairness in ACK.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr       <= '0;
         grant_idx    <= '0;
         lat_addr     <= '0;
         lat_is_write <= 1'b0;
         lat_req_data <= '0;
         lat_mesi     <= '0;
         verify_armed <= 1'b0;
         for (int i = 0; i < NUM_L2; i++)
            slot_data[i] <= '0;
      end else begin
         if (state == ISSUE) begin
            if (!arbiter_verify)
               verify_armed <= 1'b1;
         end else begin
            verify_armed <= !arbiter_verify;
         end
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant_idx    <= next_grant;
                  lat_addr     <= req_addr[next_grant*AW +: AW];
                  lat_is_write <= req_is_write[next_grant];
                  lat_req_data <= req_data[next_grant*DW +: DW];
               end
            end
            CAPTURE: begin
               for (int i = 0; i < NUM_L2; i++) begin
                  if (2'(i) == grant_idx)
                     slot_data[i] <= lat_req_data;
                  else
                     slot_data[i] <= snoop_data[i*DW +: DW];
               end
            end
            ISSUE: begin
               if (verify_accept)
                  lat_mesi <= mesi_state_to_cache;
               else if (timeout_hit)
                  lat_mesi <= '0;
            end
            ACK: begin
               rr_ptr <= grant_idx + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_coherence_request_sequencer.sv
// tb_l2_coherence_request_sequencer
// Directed bench for the L2 coherence request sequencer: reset state, single
// read, write notice with snoop merge, round-robin fairness, reset during
// ISSUE, delayed/stale verify and (with ARB_SEQ_TIMEOUT_EN) the ISSUE watchdog.
module tb_l2_coherence_request_sequencer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      req_valid;
   logic [3:0]      req_is_write;
   logic [4*AW-1:0] req_addr;
   logic [4*DW-1:0] req_data;
   logic [AW-1:0]   snoop_addr;
   logic [3:0]      snoop_req;
   logic [4*DW-1:0] snoop_data;
   logic [AW-1:0]   block_addr;
   logic [DW-1:0]   l2a_data, l2b_data, l2c_data, l2d_data;
   logic            read_update;
   logic            write_update;
   logic            ack;
   logic [MW-1:0]   mesi_in;
   logic            verify;
   logic [3:0]      resp_valid;
   logic [MW-1:0]   resp_mesi;
   logic            busy;
`ifdef ARB_SEQ_TIMEOUT_EN
   logic            timeout_err;
`endif

   int totalCount = 0;
   int badCount   = 0;

   l2_coherence_request_sequencer #(
      .ADDRESS_WIDTH(AW),
      .MAIN_MEMORY_DATA_WIDTH(DW),
      .MESI_STATE_WIDTH(MW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_is_write(req_is_write),
      .req_addr(req_addr),
      .req_data(req_data),
      .snoop_addr(snoop_addr),
      .snoop_req(snoop_req),
      .snoop_data(snoop_data),
      .block_to_determine_mesi_state_from_arbiter(block_addr),
      .L2a_local_data(l2a_data),
      .L2b_local_data(l2b_data),
      .L2c_local_data(l2c_data),
      .L2d_local_data(l2d_data),
      .arbiter_read_update_from_L2_cache_modules(read_update),
      .arbiter_write_update_from_L2_cache_modules(write_update),
      .acknowledge_arbiter_verify(ack),
      .mesi_state_to_cache(mesi_in),
      .arbiter_verify(verify),
      .resp_valid(resp_valid),
      .resp_mesi_state(resp_mesi),
      .busy(busy)
`ifdef ARB_SEQ_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the per-L2 request valid and direction lines.
   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] isWrite);
      req_valid    = valid;
      req_is_write = isWrite;
   endtask

   // Set address and local data for one requester.
   task automatic setSlot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // All sequencer outputs must be zero (reset / idle view).
   task automatic checkQuiet(input string tag);
      checkOutput(tag, 64'(|{snoop_addr, snoop_req, block_addr, l2a_data, l2b_data, l2c_data,
                             l2d_data, read_update, write_update, ack, resp_valid, resp_mesi, busy}),
                  64'd0);
   endtask

   // Wait (bounded) at negedges until an update line is presented to the arbiter.
   task automatic waitForIssue(input string tag);
      for (int c = 0; c < 20; c++) begin
         if (read_update || write_update)
            return;
         @(negedge clk);
      end
      checkOutput(tag, 64'd0, 64'd1);
   endtask

   function automatic logic [DW-1:0] localData(input int g);
      case (g)
         0: return l2a_data;
         1: return l2b_data;
         2: return l2c_data;
         default: return l2d_data;
      endcase
   endfunction

   initial begin
      reset      = 1'b0;
      verify     = 1'b0;
      mesi_in    = '0;
      snoop_data = '0;
      req_addr   = '0;
      req_data   = '0;
      applyStimulus(4'b0000, 4'b0000);
      repeat (2) @(negedge clk);
      checkQuiet("reset_outputs");

      // Fairness: all four requesters pending from reset.
      for (int i = 0; i < 4; i++)
         setSlot(i, 32'((i + 1) * 32'h100), 32'((i + 1) * 32'h11));
      applyStimulus(4'b1111, 4'b0000);
      reset = 1'b1;
      for (int r = 0; r < 5; r++) begin
         int g;
         g = r % 4;
         waitForIssue("fair_wait");
         checkOutput("fair_addr", 64'(block_addr), 64'((g + 1) * 32'h100));
         checkOutput("fair_data", 64'(localData(g)), 64'((g + 1) * 32'h11));
         verify  = 1'b1;
         mesi_in = 2'd1;
         @(negedge clk);
         checkOutput("fair_resp", 64'(resp_valid), 64'(4'b0001 << g));
         verify = 1'b0;
         if (r == 4)
            applyStimulus(4'b0000, 4'b0000);
         @(negedge clk);
         checkOutput("fair_resp_once", 64'(resp_valid), 64'd0);
      end
      @(negedge clk);
      checkOutput("fair_idle", 64'(busy), 64'd0);

      // Single read from L2b, empty snoops, verify on first ISSUE cycle.
      setSlot(1, 32'h040, 32'hAA);
      applyStimulus(4'b0010, 4'b0000);
      @(negedge clk);
      checkOutput("rd_snoop_req", 64'(snoop_req), 64'hD);
      checkOutput("rd_snoop_addr", 64'(snoop_addr), 64'h040);
      checkOutput("rd_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("rd_capture_quiet", 64'({snoop_req, read_update}), 64'd0);
      @(negedge clk);
      checkOutput("rd_update", 64'({read_update, write_update}), 64'b10);
      checkOutput("rd_block", 64'(block_addr), 64'h040);
      checkOutput("rd_l2b", 64'(l2b_data), 64'hAA);
      checkOutput("rd_l2a", 64'(l2a_data), 64'd0);
      verify  = 1'b1;
      mesi_in = 2'd2;
      @(negedge clk);
      checkOutput("rd_resp", 64'(resp_valid), 64'b0010);
      checkOutput("rd_mesi", 64'(resp_mesi), 64'd2);
      checkOutput("rd_ack", 64'(ack), 64'd1);
      checkOutput("rd_update_drop", 64'(read_update), 64'd0);
      applyStimulus(4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput("rd_drain_resp", 64'(resp_valid), 64'd0);
      checkOutput("rd_drain_ack", 64'(ack), 64'd1);
      verify = 1'b0;
      @(negedge clk);
      checkOutput("rd_ack_drop", 64'({ack, busy}), 64'd0);

      // Write notice from L2a (rr_ptr now 2, so the search wraps to a).
      setSlot(0, 32'h080, 32'h55);
      applyStimulus(4'b0001, 4'b0001);
      @(negedge clk);
      checkOutput("wr_snoop_req", 64'(snoop_req), 64'hE);
      snoop_data[2*DW +: DW] = 32'h77;
      snoop_data[3*DW +: DW] = 32'h99;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checkOutput("wr_update", 64'({read_update, write_update}), 64'b01);
         checkOutput("wr_l2a", 64'(l2a_data), 64'h55);
         checkOutput("wr_l2c_snoop", 64'(l2c_data), 64'h77);
         checkOutput("wr_l2d_snoop", 64'(l2d_data), 64'h99);
         if (k == 2) begin
            verify  = 1'b1;
            mesi_in = 2'd3;
         end
         @(negedge clk);
      end
      checkOutput("wr_resp", 64'(resp_valid), 64'b0001);
      checkOutput("wr_mesi", 64'(resp_mesi), 64'd3);
      checkOutput("wr_update_drop", 64'(write_update), 64'd0);
      applyStimulus(4'b0000, 4'b0000);
      verify     = 1'b0;
      snoop_data = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset during ISSUE, then restart with rr_ptr back at 0.
      setSlot(2, 32'h0C0, 32'hCC);
      applyStimulus(4'b0100, 4'b0000);
      waitForIssue("rst_wait");
      checkOutput("rst_pre_update", 64'(read_update), 64'd1);
      reset = 1'b0;
      #1;
      checkQuiet("reset_async");
      setSlot(0, 32'h0A0, 32'h0A);
      applyStimulus(4'b0101, 4'b0000);
      @(negedge clk);
      checkQuiet("reset_held");
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_restart_req", 64'(snoop_req), 64'hE);
      checkOutput("rst_restart_addr", 64'(snoop_addr), 64'h0A0);
      applyStimulus(4'b0000, 4'b0000);
      waitForIssue("drop_wait");
      checkOutput("drop_block", 64'(block_addr), 64'h0A0);
      verify  = 1'b1;
      mesi_in = 2'd1;
      @(negedge clk);
      checkOutput("drop_resp", 64'(resp_valid), 64'b0001);
      verify = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Stale verify on entry, then a 10-cycle ISSUE for L2d.
      setSlot(3, 32'h0E0, 32'hDD);
      applyStimulus(4'b1000, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      verify = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         checkOutput("dly_block", 64'(block_addr), 64'h0E0);
         checkOutput("dly_data", 64'(l2d_data), 64'hDD);
         checkOutput("dly_update", 64'({read_update, write_update, busy}), 64'b101);
         checkOutput("dly_no_resp", 64'(resp_valid), 64'd0);
         verify  = (k == 1) || (k == 10);
         mesi_in = 2'd1;
         @(negedge clk);
      end
      checkOutput("dly_resp", 64'(resp_valid), 64'b1000);
      checkOutput("dly_mesi", 64'(resp_mesi), 64'd1);
      verify = 1'b0;
      applyStimulus(4'b0000, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      checkOutput("dly_idle", 64'(busy), 64'd0);

`ifdef ARB_SEQ_TIMEOUT_EN
      // Watchdog: verify never arrives.
      begin
         int issueCycles;
         setSlot(1, 32'h140, 32'h1B);
         applyStimulus(4'b0010, 4'b0000);
         waitForIssue("to_wait");
         issueCycles = 0;
         while (read_update && issueCycles < 40) begin
            issueCycles++;
            @(negedge clk);
         end
         checkOutput("to_len", 64'(issueCycles), 64'd32);
         checkOutput("to_resp", 64'(resp_valid), 64'b0010);
         checkOutput("to_mesi", 64'(resp_mesi), 64'd0);
         checkOutput("to_err", 64'(timeout_err), 64'd1);
         applyStimulus(4'b0000, 4'b0000);
         repeat (3) @(negedge clk);
         checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);
         checkOutput("to_idle", 64'(busy), 64'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
